// File: rtl/noc_load_engine.sv
// noc_load_engine: copies len words from data memory (src_addr) to the NoC (dst_addr), one word in flight.
// Define NOC_LOAD_BOUNDS_CHECK_EN to reject len==0 or len>256 with a combined done/err pulse.
module noc_load_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [31:0] len,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        noc_valid,
  input  logic        noc_ready,
  output logic [31:0] noc_addr,
  output logic [31:0] noc_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, PUSH, FINISH} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] src;
  logic [31:0] dst;
  logic [31:0] remaining;
  logic [31:0] buffer;
  logic        len_reject;
  logic        accept;
  logic        handshake;
  logic        last_word;

`ifdef NOC_LOAD_BOUNDS_CHECK_EN
  logic err_flag;
  assign len_reject = (len == 32'd0) || (len > 32'd256);
`else
  assign len_reject = (len == 32'd0);
`endif

  assign accept    = (state == IDLE) && start;
  assign handshake = (state == PUSH) && noc_ready;
  assign last_word = (remaining == 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = len_reject ? FINISH : RD_REQ;
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: if (rd_valid) state_next = PUSH;
      PUSH:    if (noc_ready) state_next = last_word ? FINISH : RD_REQ;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Addresses advance only on a NoC handshake, so a stalled beat keeps its addr/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src       <= 32'd0;
      dst       <= 32'd0;
      remaining <= 32'd0;
      buffer    <= 32'd0;
    end else begin
      if (accept) begin
        src       <= src_addr;
        dst       <= dst_addr;
        remaining <= len;
      end else if (handshake) begin
        src       <= src + 32'd4;
        dst       <= dst + 32'd4;
        remaining <= remaining - 32'd1;
      end
      if ((state == RD_WAIT) && rd_valid) buffer <= rd_data;
    end
  end

`ifdef NOC_LOAD_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_flag <= 1'b0;
    else if (accept) err_flag <= len_reject;
  end
`endif

  always_comb begin
    rd_req    = 1'b0;
    rd_addr   = 32'd0;
    noc_valid = 1'b0;
    noc_addr  = 32'd0;
    noc_data  = 32'd0;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      RD_REQ: begin
        rd_req  = 1'b1;
        rd_addr = src;
      end
      PUSH: begin
        noc_valid = 1'b1;
        noc_addr  = dst;
        noc_data  = buffer;
      end
      FINISH: begin
        done = 1'b1;
`ifdef NOC_LOAD_BOUNDS_CHECK_EN
        err  = err_flag;
`endif
      end
      default: ;
    endcase
  end

endmodule
